// File: rtl/or_nand_tree_pipe.sv
// Pipelined 8-input OR reduction built from NAND-based or_nand leaf cells.
// Three register stages (4 -> 2 -> 1) with valid/ready flow control and a saturating hit counter.

module or_nand (
    input  logic a,
    input  logic b,
    output logic y
);
    logic na_s;
    logic nb_s;

    assign na_s = ~a;
    assign nb_s = ~b;
    assign y    = ~(na_s & nb_s);
endmodule

module or_nand_tree_pipe #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             a,
    input  logic             b,
    input  logic             c,
    input  logic             d,
    input  logic             e,
    input  logic             f,
    input  logic             g,
    input  logic             h,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             y,
    output logic [CNT_W-1:0] hit_cnt
);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [3:0]       s_r;
    logic [1:0]       t_r;
    logic             y_r;
    logic             v1_r;
    logic             v2_r;
    logic             v3_r;
    logic [CNT_W-1:0] cnt_r;

    logic [3:0] leaf_s;
    logic [1:0] mid_s;
    logic       root_s;
    logic       rdy1_s;
    logic       rdy2_s;
    logic       rdy3_s;
    logic       out_xfer_s;

    or_nand u_leaf0 (.a(a), .b(b), .y(leaf_s[0]));
    or_nand u_leaf1 (.a(c), .b(d), .y(leaf_s[1]));
    or_nand u_leaf2 (.a(e), .b(f), .y(leaf_s[2]));
    or_nand u_leaf3 (.a(g), .b(h), .y(leaf_s[3]));
    or_nand u_mid0  (.a(s_r[0]), .b(s_r[1]), .y(mid_s[0]));
    or_nand u_mid1  (.a(s_r[2]), .b(s_r[3]), .y(mid_s[1]));
    or_nand u_root  (.a(t_r[0]), .b(t_r[1]), .y(root_s));

    // An empty stage is always ready, so bubbles are squeezed out under backpressure.
    assign rdy3_s     = !v3_r || out_ready;
    assign rdy2_s     = !v2_r || rdy3_s;
    assign rdy1_s     = !v1_r || rdy2_s;
    assign in_ready   = rdy1_s;
    assign out_xfer_s = v3_r && out_ready;

    assign out_valid = v3_r;
    assign y         = y_r;
    assign hit_cnt   = cnt_r;

    // Stage 1: leaf results; data only captured for a real transaction.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1_r <= 1'b0;
            s_r  <= 4'b0000;
        end else if (rdy1_s) begin
            v1_r <= in_valid;
            if (in_valid) begin
                s_r <= leaf_s;
            end
        end
    end

    // Stage 2: middle level of the tree.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v2_r <= 1'b0;
            t_r  <= 2'b00;
        end else if (rdy2_s) begin
            v2_r <= v1_r;
            if (v1_r) begin
                t_r <= mid_s;
            end
        end
    end

    // Stage 3: root result held stable while the consumer stalls.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v3_r <= 1'b0;
            y_r  <= 1'b0;
        end else if (rdy3_s) begin
            v3_r <= v2_r;
            if (v2_r) begin
                y_r <= root_s;
            end
        end
    end

    // Saturating count of delivered results equal to one.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (out_xfer_s && y_r && (cnt_r != CNT_MAX)) begin
            cnt_r <= cnt_r + CNT_ONE;
        end
    end
endmodule

// File: tb/tb_or_nand_tree_pipe.sv
// Directed and random checks of or_nand_tree_pipe; a CNT_W=2 copy shares all inputs
// so counter saturation is observed alongside the default-width instance.

module tb_or_nand_tree_pipe;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       out_ready;
    logic       a, b, c, d, e, f, g, h;
    logic       in_ready, out_valid, y;
    logic [7:0] hit_cnt;
    logic       in_ready2, out_valid2, y2;
    logic [1:0] hit_cnt2;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    or_nand_tree_pipe #(.CNT_W(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g), .h(h),
        .out_valid(out_valid), .out_ready(out_ready), .y(y), .hit_cnt(hit_cnt)
    );

    or_nand_tree_pipe #(.CNT_W(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
        .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g), .h(h),
        .out_valid(out_valid2), .out_ready(out_ready), .y(y2), .hit_cnt(hit_cnt2)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic set_vec(input logic [7:0] v);
        {h, g, f, e, d, c, b, a} = v;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] bp_vec [5];
        logic       bp_exp_y [5];
        logic       exp_rdy [5];
        int         exp_hit8 [12];
        int         exp_hit2 [12];
        int         idx;
        int         k;
        int         m8;
        logic [7:0] v;
        logic       sb [$];
        logic       ey;

        bp_vec   = '{8'h04, 8'h00, 8'h20, 8'h00, 8'h02};
        bp_exp_y = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        exp_rdy  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        exp_hit8 = '{0, 0, 0, 1, 2, 3, 4, 5, 6, 7, 8, 9};
        exp_hit2 = '{0, 0, 0, 1, 2, 3, 3, 3, 3, 3, 3, 3};

        // Reset with a valid vector presented: nothing may be captured.
        rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b1; set_vec(8'hff);
        tick(); tick();
        check_val("rst_in_ready", in_ready, 1);
        check_val("rst_out_valid", out_valid, 0);
        check_val("rst_y", y, 0);
        check_val("rst_hit", hit_cnt, 0);
        check_val("rst_hit2", hit_cnt2, 0);
        rst_n = 1'b1; in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_val("rst_no_capture", out_valid, 0);
        end

        // Single all-zero vector: three edges to output, one-cycle valid.
        set_vec(8'h00); in_valid = 1'b1;
        tick(); in_valid = 1'b0;
        check_val("single_lat1", out_valid, 0);
        tick();
        check_val("single_lat2", out_valid, 0);
        tick();
        check_val("single_valid", out_valid, 1);
        check_val("single_y", y, 0);
        tick();
        check_val("single_gone", out_valid, 0);
        check_val("single_hit", hit_cnt, 0);

        // One-hot sweep a..h then all-ones, back-to-back.
        for (int cyc = 0; cyc < 12; cyc++) begin
            in_valid = (cyc < 9);
            v = (cyc < 8) ? (8'd1 << cyc) : 8'hff;
            set_vec(v);
            tick();
            if (cyc >= 2 && cyc <= 10) begin
                check_val("sweep_valid", out_valid, 1);
                check_val("sweep_y", y, 1);
            end
            if (cyc == 11) check_val("sweep_end_valid", out_valid, 0);
            check_val("sweep_hit8", hit_cnt, exp_hit8[cyc]);
            check_val("sweep_hit2", hit_cnt2, exp_hit2[cyc]);
        end

        // Backpressure: only three fit while the consumer stalls.
        out_ready = 1'b0; idx = 0;
        for (int cyc = 0; cyc < 5; cyc++) begin
            in_valid = 1'b1;
            set_vec(bp_vec[idx]);
            #1;
            check_val("bp_in_ready", in_ready, exp_rdy[cyc]);
            if (in_ready) idx++;
            tick();
            if (cyc >= 2) begin
                check_val("bp_stall_valid", out_valid, 1);
                check_val("bp_stall_y", y, 1);
            end
        end
        check_val("bp_accepted", idx, 3);
        out_ready = 1'b1;
        #1;
        check_val("bp_ready_same_cycle", in_ready, 1);
        k = 0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            in_valid = (idx < 5);
            set_vec(bp_vec[(idx < 5) ? idx : 0]);
            #1;
            if (out_valid && out_ready) begin
                if (k < 5) check_val("bp_order_y", y, bp_exp_y[k]);
                k++;
            end
            if (in_valid && in_ready) idx++;
            tick();
        end
        check_val("bp_delivered", k, 5);
        check_val("bp_all_accepted", idx, 5);
        check_val("bp_hit8", hit_cnt, 12);
        check_val("bp_hit2", hit_cnt2, 3);

        // Random traffic against a scoreboard of OR-reduced accepted vectors.
        m8 = 12;
        for (int i = 0; i < 1010; i++) begin
            in_valid  = (i < 1000) ? 1'($urandom_range(0, 1)) : 1'b0;
            out_ready = (i < 1000) ? 1'($urandom_range(0, 1)) : 1'b1;
            v = 8'($urandom);
            set_vec(v);
            #1;
            check_val("rnd_in_ready", in_ready, !((sb.size() == 3) && !out_ready));
            if (out_valid && out_ready) begin
                check_val("rnd_not_spurious", (sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    ey = sb.pop_front();
                    check_val("rnd_y", y, ey);
                    if (ey && m8 < 255) m8++;
                end
            end
            if (in_valid && in_ready) sb.push_back(|v);
            tick();
        end
        check_val("rnd_drained", sb.size(), 0);
        check_val("rnd_out_valid", out_valid, 0);
        check_val("rnd_hit8", hit_cnt, m8);
        check_val("rnd_hit2", hit_cnt2, 3);

        // Reset while full and stalled.
        out_ready = 1'b0; in_valid = 1'b1; set_vec(8'hff);
        tick(); tick(); tick();
        in_valid = 1'b0;
        #1;
        check_val("mid_full_valid", out_valid, 1);
        check_val("mid_full_ready", in_ready, 0);
        rst_n = 1'b0; in_valid = 1'b1;
        tick();
        check_val("mid_rst_valid", out_valid, 0);
        check_val("mid_rst_y", y, 0);
        check_val("mid_rst_hit", hit_cnt, 0);
        check_val("mid_rst_hit2", hit_cnt2, 0);
        check_val("mid_rst_ready", in_ready, 1);
        rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_val("mid_no_stale", out_valid, 0);
        end
        set_vec(8'h80); in_valid = 1'b1;
        tick(); in_valid = 1'b0;
        tick();
        check_val("mid_h_lat", out_valid, 0);
        tick();
        check_val("mid_h_valid", out_valid, 1);
        check_val("mid_h_y", y, 1);
        tick();
        check_val("mid_h_hit", hit_cnt, 1);
        check_val("mid_h_gone", out_valid, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
